// File: rtl/mem_writer_pkg.sv
// Shared types and helpers for the memory stream writer/reader family.
// No logic of its own; the wrap helper is used wherever an address advances.
// Not applicable for backpressure: package only.
package mem_writer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Explicit compare against the last word so DEPTH need not be a power of two.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/mem_addr_counter.sv
// Loadable memory address register with wrap at DEPTH-1 and an increment enable.
// Latency: load/increment take effect on the next rising edge.
// Backpressure: none; the owner gates inc with its own handshake.
module mem_addr_counter #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] addr
);
    import mem_writer_pkg::*;

    logic [31:0]   load_ext;
    logic [AW-1:0] load_mod;

    // load_addr < 2^AW < 2*DEPTH, so a single subtract is a full modulo.
    assign load_ext = 32'(load_addr);
    assign load_mod = (load_ext >= 32'(DEPTH)) ? AW'(load_ext - 32'(DEPTH)) : load_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_mod;
        end else if (inc) begin
            addr <= AW'(next_addr(32'(addr), DEPTH));
        end
    end

endmodule

// File: rtl/mem_stream_writer.sv
// Writes a valid/ready word stream into consecutive memory words from BASE for LEN words.
// Latency: accepted beat appears on WEN/WADDR/WDATA one cycle later; 1 word/cycle sustained.
// Backpressure: IN_READY only while a transfer is active and not being aborted.
module mem_stream_writer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             START,
    input  logic [AW-1:0]    BASE,
    input  logic [AW:0]      LEN,
    input  logic             ABORT,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_READY,
    output logic [AW-1:0]    WADDR,
    output logic [WIDTH-1:0] WDATA,
    output logic             WEN,
    output logic             BUSY,
    output logic             DONE
);
    import mem_writer_pkg::*;

    state_t        state;
    logic [AW:0]   remaining;
    logic [AW-1:0] cur_addr;
    logic          start_load;
    logic          beat;

    assign BUSY       = (state != IDLE);
    assign IN_READY   = BUSY & ~ABORT;
    assign beat       = IN_VALID & IN_READY;
    assign start_load = (state == IDLE) & START & (LEN != '0);

    mem_addr_counter #(.DEPTH(DEPTH)) u_addr (
        .clk       (CLK),
        .rst       (ASYNCRESET),
        .load      (start_load),
        .load_addr (BASE),
        .inc       (beat),
        .addr      (cur_addr)
    );

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= IDLE;
            remaining <= '0;
            WEN       <= 1'b0;
            WADDR     <= '0;
            WDATA     <= '0;
            DONE      <= 1'b0;
        end else begin
            WEN  <= 1'b0;
            DONE <= 1'b0;
            if (state == IDLE) begin
                if (START) begin
                    // A zero-length request completes immediately without a write.
                    if (LEN == '0) begin
                        DONE <= 1'b1;
                    end else begin
                        remaining <= LEN;
                        state     <= mem_writer_pkg::BUSY;
                    end
                end
            end else begin
                if (ABORT) begin
                    state     <= IDLE;
                    remaining <= '0;
                end else if (beat) begin
                    WEN       <= 1'b1;
                    WADDR     <= cur_addr;
                    WDATA     <= IN_DATA;
                    remaining <= remaining - (AW+1)'(1);
                    if (remaining == (AW+1)'(1)) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_writer.sv
// Scenario bench for mem_stream_writer with a scoreboard of expected writes and a memory model.
module tb_mem_stream_writer;

    logic       CLK;
    logic       ASYNCRESET;
    logic       START;
    logic [1:0] BASE;
    logic [2:0] LEN;
    logic       ABORT;
    logic       IN_VALID;
    logic [4:0] IN_DATA;
    logic       IN_READY;
    logic [1:0] WADDR;
    logic [4:0] WDATA;
    logic       WEN;
    logic       BUSY;
    logic       DONE;

    typedef struct packed {
        logic [1:0] addr;
        logic [4:0] data;
        logic       done;
    } wr_t;

    wr_t        exp_q[$];
    logic [4:0] mem [4];
    int         n_checks;
    int         n_fail;

    mem_stream_writer #(.WIDTH(5), .DEPTH(4)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .START(START), .BASE(BASE), .LEN(LEN),
        .ABORT(ABORT), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .WADDR(WADDR), .WDATA(WDATA), .WEN(WEN), .BUSY(BUSY), .DONE(DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stand-in for the attached memory's write port.
    always @(posedge CLK) begin
        if (WEN) mem[WADDR] <= WDATA;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ASYNCRESET = 1'b1; START = 1'b0; BASE = '0; LEN = '0;
        ABORT = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
        #2;
        n_checks++;
        if ({WEN, WADDR, WDATA, DONE, BUSY, IN_READY} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h done=%b busy=%b rdy=%b, want all 0",
                     WEN, WADDR, WDATA, DONE, BUSY, IN_READY);
        end
        step(); step();
        ASYNCRESET = 1'b0;
        step();
        n_checks++;
        if ({WEN, DONE, BUSY} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got wen=%b done=%b busy=%b, want 0 0 0", WEN, DONE, BUSY);
        end
    endtask

    task automatic test_full_load();
        logic [4:0] vals [4];
        wr_t e;
        vals[0] = 5'h07; vals[1] = 5'h0A; vals[2] = 5'h13; vals[3] = 5'h00;
        START = 1'b1; BASE = 2'd0; LEN = 3'd4;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1; IN_DATA = vals[i];
            exp_q.push_back({2'(i), vals[i], (i == 3)});
            step();
            e = exp_q.pop_front();
            n_checks++;
            if ({WEN, WADDR, WDATA, DONE} !== {1'b1, e.addr, e.data, e.done}) begin
                n_fail++;
                $display("FAIL load_write%0d: got wen=%b addr=%0d data=%h done=%b, want 1 %0d %h %b",
                         i, WEN, WADDR, WDATA, DONE, e.addr, e.data, e.done);
            end
        end
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL load_busy_at_done: got %b want 0", BUSY);
        end
        IN_VALID = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[i] !== vals[i]) begin
                n_fail++;
                $display("FAIL load_readback%0d: got %h want %h", i, mem[i], vals[i]);
            end
        end
    endtask

    task automatic test_wrap_backpressure();
        logic       vld_pat [5];
        logic [4:0] d;
        logic [1:0] a;
        int         k;
        wr_t        e;
        vld_pat[0] = 1; vld_pat[1] = 0; vld_pat[2] = 1; vld_pat[3] = 0; vld_pat[4] = 1;
        START = 1'b1; BASE = 2'd3; LEN = 3'd3;
        step();
        START = 1'b0;
        d = 5'd1; a = 2'd3; k = 0;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = vld_pat[c];
            IN_DATA  = vld_pat[c] ? d : 5'h1F;
            if (vld_pat[c]) begin
                k++;
                exp_q.push_back({a, d, (k == 3)});
                a = (a == 2'd3) ? 2'd0 : a + 2'd1;
                d = d + 5'd1;
            end
            step();
            n_checks++;
            if (vld_pat[c]) begin
                e = exp_q.pop_front();
                if ({WEN, WADDR, WDATA, DONE} !== {1'b1, e.addr, e.data, e.done}) begin
                    n_fail++;
                    $display("FAIL wrap_write_cyc%0d: got wen=%b addr=%0d data=%h done=%b, want 1 %0d %h %b",
                             c, WEN, WADDR, WDATA, DONE, e.addr, e.data, e.done);
                end
            end else if (WEN !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_gap_cyc%0d: got wen=%b want 0", c, WEN);
            end
        end
        IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_len_zero();
        START = 1'b1; BASE = 2'd2; LEN = 3'd0;
        #1;
        n_checks++;
        if ({IN_READY, BUSY} !== 2'b00) begin
            n_fail++;
            $display("FAIL len0_start: got rdy=%b busy=%b want 0 0", IN_READY, BUSY);
        end
        step();
        START = 1'b0;
        n_checks++;
        if ({DONE, WEN, BUSY, IN_READY} !== 4'b1000) begin
            n_fail++;
            $display("FAIL len0_done: got done=%b wen=%b busy=%b rdy=%b, want 1 0 0 0",
                     DONE, WEN, BUSY, IN_READY);
        end
        step();
        n_checks++;
        if ({DONE, WEN, BUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL len0_after: got done=%b wen=%b busy=%b, want 0 0 0", DONE, WEN, BUSY);
        end
    endtask

    task automatic test_abort();
        int writes, dones;
        writes = 0; dones = 0;
        START = 1'b1; BASE = 2'd0; LEN = 3'd4;
        step();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1; IN_DATA = 5'h11 + 5'(i);
            step();
            writes += int'(WEN); dones += int'(DONE);
        end
        ABORT = 1'b1; IN_VALID = 1'b1; IN_DATA = 5'h15;
        #1;
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: got %b want 0", IN_READY);
        end
        step();
        ABORT = 1'b0; IN_VALID = 1'b0;
        writes += int'(WEN); dones += int'(DONE);
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b want 0", BUSY);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            writes += int'(WEN); dones += int'(DONE);
        end
        n_checks++;
        if (writes != 2 || dones != 0) begin
            n_fail++;
            $display("FAIL abort_counts: got writes=%0d dones=%0d, want 2 0", writes, dones);
        end
    endtask

    task automatic test_async_reset();
        wr_t e;
        START = 1'b1; BASE = 2'd0; LEN = 3'd2;
        step();
        START = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 5'h09;
        step();
        n_checks++;
        if (WEN !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre_wen: got %b want 1", WEN);
        end
        #2 ASYNCRESET = 1'b1;
        #1;
        n_checks++;
        if ({WEN, BUSY, DONE} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_mid: got wen=%b busy=%b done=%b, want 0 0 0", WEN, BUSY, DONE);
        end
        #1 ASYNCRESET = 1'b0;
        IN_VALID = 1'b0;
        step();
        START = 1'b1; BASE = 2'd1; LEN = 3'd1;
        step();
        START = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 5'h1E;
        exp_q.push_back({2'd1, 5'h1E, 1'b1});
        step();
        IN_VALID = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({WEN, WADDR, WDATA, DONE} !== {1'b1, e.addr, e.data, e.done}) begin
            n_fail++;
            $display("FAIL areset_rewrite: got wen=%b addr=%0d data=%h done=%b, want 1 %0d %h %b",
                     WEN, WADDR, WDATA, DONE, e.addr, e.data, e.done);
        end
        step();
        n_checks++;
        if (mem[1] !== 5'h1E) begin
            n_fail++;
            $display("FAIL areset_readback: got %h want 1e", mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        START = 1'b1; BASE = 2'd2; LEN = 3'd1;
        step();
        START = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 5'h05;
        exp_q.push_back({2'd2, 5'h05, 1'b1});
        step();
        IN_VALID = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({WEN, WADDR, WDATA, DONE} !== {1'b1, e.addr, e.data, e.done}) begin
            n_fail++;
            $display("FAIL b2b_first: got wen=%b addr=%0d data=%h done=%b, want 1 %0d %h %b",
                     WEN, WADDR, WDATA, DONE, e.addr, e.data, e.done);
        end
        START = 1'b1; BASE = 2'd0; LEN = 3'd1;
        step();
        START = 1'b0;
        n_checks++;
        if ({BUSY, IN_READY} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b rdy=%b want 1 1", BUSY, IN_READY);
        end
        IN_VALID = 1'b1; IN_DATA = 5'h06;
        exp_q.push_back({2'd0, 5'h06, 1'b1});
        step();
        IN_VALID = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({WEN, WADDR, WDATA, DONE} !== {1'b1, e.addr, e.data, e.done}) begin
            n_fail++;
            $display("FAIL b2b_second: got wen=%b addr=%0d data=%h done=%b, want 1 %0d %h %b",
                     WEN, WADDR, WDATA, DONE, e.addr, e.data, e.done);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_load();
        test_wrap_backpressure();
        test_len_zero();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stream_writer.md
Name: mem_stream_writer

Overview:
- Write-side companion to the team's `coreir_mem` wrapper.
- Accepts a valid/ready stream of data words and writes them into consecutive memory locations through the memory's write port (`waddr`/`wdata`/`wen`).
- Each transfer starts from a programmable base address and has a programmable word count; completion is signalled with a one-cycle pulse.
- Used to load lookup tables and scratch memories at run time instead of relying on an init image.

Parameters:
- WIDTH, 5, data word width; must match the attached memory's width.
- DEPTH, 4, number of memory words; need not be a power of two.
- AW, $clog2(DEPTH) (minimum 1), address width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- START  input  1  pulse; requests a new transfer; honoured only when idle.
- BASE  input  AW  first write address; sampled when START is accepted.
- LEN  input  AW+1  number of words to write; sampled when START is accepted.
- ABORT  input  1  terminates an active transfer.
- IN_VALID  input  1  stream word valid.
- IN_DATA  input  WIDTH  stream word.
- IN_READY  output  1  writer accepts IN_DATA this cycle.
- WADDR  output  AW  memory write address (registered).
- WDATA  output  WIDTH  memory write data (registered).
- WEN  output  1  memory write enable (registered).
- BUSY  output  1  high while a transfer is active.
- DONE  output  1  one-cycle pulse, coincident with the final WEN.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state goes to IDLE;
  - WEN, WADDR, WDATA, DONE, BUSY are all 0;
  - the address register and the remaining-word count are cleared.
- Reset asserted mid-transfer: WEN drops without waiting for a clock edge, and the transfer is lost. After reset releases, the block waits in IDLE for a new START.
- States: IDLE and BUSY.
- IDLE:
  - If START=1 and LEN=0: DONE pulses on the next cycle, no write is issued, and the state stays IDLE.
  - If START=1 and LEN>0: latch BASE into the address register and LEN into the remaining count; go to BUSY.
- BUSY:
  - IN_READY = BUSY & ~ABORT (combinational). A beat is accepted when IN_VALID & IN_READY.
  - On each accepted beat, on the next edge:
    - WEN=1, WADDR = current address, WDATA = IN_DATA.
    - The address increments; at DEPTH-1 it wraps to 0 by explicit compare (no power-of-two assumption).
    - The remaining count decrements.
  - Cycles with no accepted beat produce WEN=0 on the next edge; WADDR and WDATA hold their last values.
  - Last beat (remaining count = 1 when accepted): the next edge sets WEN=1 and DONE=1 and returns the state to IDLE, so BUSY=0 in that same cycle.
  - ABORT=1 in BUSY: no beat is accepted; the next edge goes to IDLE with WEN=0, DONE=0, and the count cleared. Words already written are not undone.
  - START while BUSY is ignored.
- Latency:
  - Stream accept to memory write: exactly 1 cycle.
  - Sustained throughput: 1 word per cycle.
- Back-to-back transfers: a START may be accepted in the cycle DONE is high, because the state is already IDLE.
- LEN > DEPTH is legal: addresses wrap, and later words overwrite earlier ones.
- BASE ≥ DEPTH: BASE is reduced modulo DEPTH when latched.

Decomposition:
- Shared package `mem_writer_pkg`:
  - state enum {IDLE, BUSY};
  - function `next_addr(addr, depth)` implementing the wrap-around.
- One natural sub-module, `mem_addr_counter`: loadable address register with wrap and increment enable. It is reusable by a future stream reader.
- Everything else stays in the top-level module.

Test Plan:
- Full load: after reset, START with BASE=0, LEN=4, then stream 5'h07, 5'h0A, 5'h13, 5'h00 with IN_VALID held high.
  - Required: WEN is high for 4 consecutive cycles at WADDR 0,1,2,3.
  - Required: DONE is high with the 4th WEN.
  - Required: reading back an attached `coreir_mem` (DEPTH 4, WIDTH 5) gives 7, 0x0A, 0x13, 0x00.
- Wrap and backpressure: START with BASE=3, LEN=3; IN_VALID toggles 1,0,1,0,1 with data 1,2,3.
  - Required: writes land at WADDR 3, 0, 1 with data 1, 2, 3.
  - Required: each write follows its beat by exactly 1 cycle, with no writes in the gap cycles.
- LEN=0: START with BASE=2, LEN=0 -> DONE pulses 1 cycle later; WEN, IN_READY and BUSY all stay 0.
- Abort: START with LEN=4; after 2 accepted beats, assert ABORT with IN_VALID=1.
  - Required: IN_READY=0 during the ABORT cycle.
  - Required: exactly 2 writes total, no DONE, and BUSY=0 on the next cycle.
- Async reset mid-transfer: assert ASYNCRESET between clock edges while WEN=1.
  - Required: WEN, BUSY and DONE go to 0 before the next edge.
  - Required: after release, a new START/LEN=1 write to BASE=1 works normally.
- Back-to-back: assert START (BASE=0, LEN=1) in the cycle DONE of a prior transfer is high.
  - Required: the new transfer is accepted.
  - Required: BUSY is high the following cycle.
